// File: rtl/disp_scan_if.sv
// Display-scan bus: load/data/decimal-point/blank requests in, segment/anode drive
// and status out. master = controller side, slave = disp_scan.
interface disp_scan_if;
  logic        load_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [3:0]  blank_i;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        pending_o;
  logic        frame_o;

  modport master (
    output load_i, data_i, dp_i, blank_i,
    input  seg, an, pending_o, frame_o
  );

  modport slave (
    input  load_i, data_i, dp_i, blank_i,
    output seg, an, pending_o, frame_o
  );
endinterface

// File: rtl/disp_scan.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous shadow register.
// Optional feature: define LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module disp_scan #(
  parameter int SCAN_DIV = 18
) (
  input logic        clk,
  input logic        rst,
  disp_scan_if.slave bus
);

  logic [SCAN_DIV-1:0] presc;
  logic [1:0]          idx;
  logic [15:0]         shadow, disp;
  logic [3:0]          shadow_dp, disp_dp;
  logic                pending;
  logic [3:0]          an_r;
  logic [7:0]          seg_r;

  logic        tick, boundary, xfer;
  logic [1:0]  idx_nxt;
  logic [15:0] disp_nxt;
  logic [3:0]  disp_dp_nxt;
  logic [3:0]  nib;
  logic [3:0]  blank_eff;
  logic [3:0]  an_nxt;
  logic [7:0]  seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick     = &presc;
  assign boundary = tick && (idx == 2'd3);
  // A load in the boundary cycle wins over the older shadow: no transfer that edge.
  assign xfer     = boundary && pending && !bus.load_i;

  // Decode from the post-edge display so the first digit of a new frame
  // already shows the new content.
  always_comb begin
    disp_nxt    = xfer ? shadow : disp;
    disp_dp_nxt = xfer ? shadow_dp : disp_dp;
    idx_nxt     = idx + 2'd1;
    nib         = disp_nxt[{idx_nxt, 2'b00} +: 4];
    blank_eff   = bus.blank_i;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic [3:1] lz;
      lz[3] = (disp_nxt[15:12] == 4'h0) && !disp_dp_nxt[3];
      lz[2] = lz[3] && (disp_nxt[11:8] == 4'h0) && !disp_dp_nxt[2];
      lz[1] = lz[2] && (disp_nxt[7:4]  == 4'h0) && !disp_dp_nxt[1];
      blank_eff = blank_eff | {lz, 1'b0};
    end
`endif
    an_nxt  = blank_eff[idx_nxt] ? 4'b1111 : ~(4'b0001 << idx_nxt);
    seg_nxt = {~disp_dp_nxt[idx_nxt], hex7(nib)};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the shadow and display registers are reset too, since a
  // reset must discard any queued content.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      disp      <= 16'h0000;
      disp_dp   <= 4'h0;
      pending   <= 1'b0;
      an_r      <= 4'b1110;
      seg_r     <= 8'hC0;
    end else begin
      presc <= presc + {{(SCAN_DIV-1){1'b0}}, 1'b1};
      if (bus.load_i) begin
        shadow    <= bus.data_i;
        shadow_dp <= bus.dp_i;
        pending   <= 1'b1;
      end else if (xfer) begin
        pending   <= 1'b0;
      end
      if (xfer) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
      end
      if (tick) begin
        idx   <= idx_nxt;
        an_r  <= an_nxt;
        seg_r <= seg_nxt;
      end
    end
  end

  assign bus.an        = an_r;
  assign bus.seg       = seg_r;
  assign bus.pending_o = pending;
  assign bus.frame_o   = boundary;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan at SCAN_DIV=2 (4 clocks per digit, 16 per frame).
// Expectations follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_disp_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  disp_scan_if bus();

  disp_scan #(.SCAN_DIV(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Steps until frame_o is seen; leaves the bench inside the boundary cycle.
  task automatic wait_frame(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_o === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s: frame_o not seen within 40 clocks", tag);
    end
  endtask

  task automatic test_reset;
    bus.load_i  = 1'b0;
    bus.data_i  = 16'h0000;
    bus.dp_i    = 4'h0;
    bus.blank_i = 4'h0;
    rst = 1'b1;
    tick_n(3);
    checks++;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL reset_an: got %b want 1110", bus.an); end
    checks++;
    if (bus.seg !== 8'hC0) begin failures++; $display("FAIL reset_seg: got %h want c0", bus.seg); end
    checks++;
    if (bus.pending_o !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b want 0", bus.pending_o); end
    checks++;
    if (bus.frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b want 0", bus.frame_o); end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    for (int k = 1; k <= 32; k++) begin
      int d;
      logic [3:0] ea;
      tick_n(1);
      d  = (k / 4) % 4;
      ea = (LZB && d != 0) ? 4'b1111 : ~(4'b0001 << d);
      checks++;
      if (bus.an !== ea) begin failures++; $display("FAIL scan_an k=%0d: got %b want %b", k, bus.an, ea); end
      checks++;
      if (bus.seg !== 8'hC0) begin failures++; $display("FAIL scan_seg k=%0d: got %h want c0", k, bus.seg); end
      checks++;
      if (bus.frame_o !== (k % 16 == 15)) begin
        failures++; $display("FAIL scan_frame k=%0d: got %b want %b", k, bus.frame_o, (k % 16 == 15));
      end
    end
  endtask

  task automatic test_load;
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] es [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    tick_n(5);
    bus.load_i = 1'b1; bus.data_i = 16'h12AF; bus.dp_i = 4'b0100;
    tick_n(1);
    bus.load_i = 1'b0;
    checks++;
    if (bus.pending_o !== 1'b1) begin failures++; $display("FAIL load_pending: got %b want 1", bus.pending_o); end
    wait_frame("load_wait");
    checks++;
    if (bus.pending_o !== 1'b1) begin failures++; $display("FAIL load_pending_boundary: got %b want 1", bus.pending_o); end
    tick_n(1);
    checks++;
    if (bus.pending_o !== 1'b0) begin failures++; $display("FAIL load_pending_clear: got %b want 0", bus.pending_o); end
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tick_n(4);
      checks++;
      if (bus.an !== ea[d]) begin failures++; $display("FAIL load_an d=%0d: got %b want %b", d, bus.an, ea[d]); end
      checks++;
      if (bus.seg !== es[d]) begin failures++; $display("FAIL load_seg d=%0d: got %h want %h", d, bus.seg, es[d]); end
    end
  endtask

  task automatic test_last_wins;
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame("last_sync");
    tick_n(7);
    bus.load_i = 1'b1; bus.data_i = 16'h1111; bus.dp_i = 4'h0;
    tick_n(1);
    bus.data_i = 16'h2222;
    tick_n(1);
    bus.load_i = 1'b0;
    wait_frame("last_wait");
    tick_n(1);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tick_n(4);
      checks++;
      if (bus.an !== ea[d]) begin failures++; $display("FAIL last_an d=%0d: got %b want %b", d, bus.an, ea[d]); end
      checks++;
      if (bus.seg !== 8'hA4) begin failures++; $display("FAIL last_seg d=%0d: got %h want a4", d, bus.seg); end
    end
  endtask

  task automatic test_back_to_back;
    // Load in the boundary cycle itself: deferred a whole frame.
    wait_frame("b2b_sync1");
    bus.load_i = 1'b1; bus.data_i = 16'h3333; bus.dp_i = 4'h0;
    tick_n(1);
    bus.load_i = 1'b0;
    checks++;
    if (bus.pending_o !== 1'b1) begin failures++; $display("FAIL b2b_pending_kept: got %b want 1", bus.pending_o); end
    checks++;
    if (bus.seg !== 8'hA4) begin failures++; $display("FAIL b2b_old_shown: got %h want a4", bus.seg); end
    wait_frame("b2b_wait1");
    tick_n(1);
    checks++;
    if (bus.pending_o !== 1'b0) begin failures++; $display("FAIL b2b_pending_clear: got %b want 0", bus.pending_o); end
    checks++;
    if (bus.seg !== 8'hB0) begin failures++; $display("FAIL b2b_new_shown: got %h want b0", bus.seg); end
    // Pending shadow overwritten in the boundary cycle: older content never applied.
    tick_n(6);
    bus.load_i = 1'b1; bus.data_i = 16'h4444;
    tick_n(1);
    bus.load_i = 1'b0;
    wait_frame("b2b_sync2");
    bus.load_i = 1'b1; bus.data_i = 16'h5555;
    tick_n(1);
    bus.load_i = 1'b0;
    checks++;
    if (bus.seg !== 8'hB0) begin failures++; $display("FAIL b2b_no_xfer: got %h want b0", bus.seg); end
    checks++;
    if (bus.pending_o !== 1'b1) begin failures++; $display("FAIL b2b_pending_hold: got %b want 1", bus.pending_o); end
    wait_frame("b2b_wait2");
    tick_n(1);
    checks++;
    if (bus.seg !== 8'h92) begin failures++; $display("FAIL b2b_latest: got %h want 92", bus.seg); end
  endtask

  task automatic test_blank;
    logic [3:0] ea [4] = '{4'b1110, 4'b1111, 4'b1011, 4'b0111};
    bus.blank_i = 4'b0010;
    wait_frame("blank_wait");
    tick_n(1);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tick_n(4);
      checks++;
      if (bus.an !== ea[d]) begin failures++; $display("FAIL blank_an d=%0d: got %b want %b", d, bus.an, ea[d]); end
      if (d != 1) begin
        checks++;
        if (bus.seg !== 8'h92) begin failures++; $display("FAIL blank_seg d=%0d: got %h want 92", d, bus.seg); end
      end
    end
    bus.blank_i = 4'b0000;
  endtask

  task automatic test_leading_zero;
    logic [3:0] ea [4];
    ea = LZB ? '{4'b1110, 4'b1101, 4'b1111, 4'b1111}
             : '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tick_n(3);
    bus.load_i = 1'b1; bus.data_i = 16'h0050; bus.dp_i = 4'h0;
    tick_n(1);
    bus.load_i = 1'b0;
    wait_frame("lz_wait");
    tick_n(1);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tick_n(4);
      checks++;
      if (bus.an !== ea[d]) begin failures++; $display("FAIL lz_an d=%0d: got %b want %b", d, bus.an, ea[d]); end
      if (d < 2 || !LZB) begin
        checks++;
        if (bus.seg !== ((d == 1) ? 8'h92 : 8'hC0)) begin
          failures++; $display("FAIL lz_seg d=%0d: got %h want %h", d, bus.seg, (d == 1) ? 8'h92 : 8'hC0);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    tick_n(5);
    bus.load_i = 1'b1; bus.data_i = 16'h8888; bus.dp_i = 4'hF;
    tick_n(1);
    bus.load_i = 1'b0;
    checks++;
    if (bus.pending_o !== 1'b1) begin failures++; $display("FAIL rmid_pending_pre: got %b want 1", bus.pending_o); end
    #1 rst = 1'b1;
    #2;
    checks++;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL rmid_an: got %b want 1110", bus.an); end
    checks++;
    if (bus.seg !== 8'hC0) begin failures++; $display("FAIL rmid_seg: got %h want c0", bus.seg); end
    checks++;
    if (bus.pending_o !== 1'b0) begin failures++; $display("FAIL rmid_pending: got %b want 0", bus.pending_o); end
    rst = 1'b0;
    tick_n(3);
    checks++;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL rmid_idx0_hold: got %b want 1110", bus.an); end
    tick_n(1);
    checks++;
    if (bus.an !== (LZB ? 4'b1111 : 4'b1101)) begin
      failures++; $display("FAIL rmid_idx1: got %b want %b", bus.an, LZB ? 4'b1111 : 4'b1101);
    end
    wait_frame("rmid_wait");
    tick_n(1);
    checks++;
    if (bus.seg !== 8'hC0) begin failures++; $display("FAIL rmid_no_old: got %h want c0", bus.seg); end
    checks++;
    if (bus.pending_o !== 1'b0) begin failures++; $display("FAIL rmid_pending_post: got %b want 0", bus.pending_o); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_last_wins();
    test_back_to_back();
    test_blank();
    test_leading_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
